button_event_scheduler: RTL and testbench
=========================================

Name: button_event_scheduler

Overview:
Multi-button front end that debounces N raw push-buttons and queues click events for a single shared consumer, such as the LFSR step/seed controller. Each button runs a press/hold/release debounce FSM, sampled on a shared prescaled tick. A completed click latches a per-button pending flag. A round-robin arbiter delivers pending clicks one at a time over a valid/ready handshake.

Parameters:
N_BTN, 4, number of buttons (2..2**ID_W)
ID_W, 2, width of evt_id
DIV, 16, sample-tick period in clk cycles (>=1); counter width is clog2(DIV), minimum 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  N_BTN  raw asynchronous button levels, 1 = pressed
evt_ready  input  1  consumer accepts event this cycle
evt_valid  output  1  event offered
evt_id  output  ID_W  index of the button whose click is offered
pending  output  N_BTN  per-button pending-click flags
evt_drop  output  1  one-cycle pulse: a click was lost because its pending flag was already set

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops, tick counter, all FSMs (WAIT), pending, evt_valid, evt_id and evt_drop go to 0. The round-robin pointer goes to N_BTN-1, so btn[0] has first priority.
- A reset asserted mid-operation discards all pending clicks and any offered event. evt_valid falls immediately.
- Synchroniser: each btn bit passes through 2 flops. The synchronised level is bs[i].
- Tick: a counter counts 0..DIV-1 and wraps to 0. tick=1 in the cycle where count==DIV-1. With DIV=1, tick is high every cycle.
- Per-button FSM, advanced only on tick (holds otherwise):
  - WAIT: bs=1 -> PRESSED; else stay WAIT.
  - PRESSED: bs=1 -> HELD; else WAIT (glitch rejected).
  - HELD: bs=1 -> stay HELD; else RELEASED.
  - RELEASED: bs=1 -> PRESSED; bs=0 -> WAIT and click[i]=1 for that cycle.
  - A click therefore requires >=2 consecutive high samples followed by 2 consecutive low samples.
- Pending flags:
  - click[i] sets pending[i] on the same edge the FSM leaves RELEASED.
  - A handshake (evt_valid & evt_ready) clears pending[evt_id].
  - Click and handshake for the same i in the same cycle: pending[i] stays 1 (new click retained), no drop.
  - Click while pending[i]=1 and not being cleared that cycle: pending stays 1 and evt_drop pulses for one cycle. Multiple simultaneous drops produce a single pulse.
- Arbiter:
  - When evt_valid=0 and pending!=0, on the next edge evt_valid=1 and evt_id = first set pending bit searching ptr+1, ptr+2, ... modulo N_BTN.
  - While evt_valid=1 & evt_ready=0, evt_valid and evt_id hold stable.
  - On handshake: pending[evt_id] clears, ptr<=evt_id, and evt_valid deasserts on that edge.
  - evt_valid is low for at least one cycle between events, so maximum throughput is one event per 2 cycles.
  - evt_ready is ignored while evt_valid=0.
- Latency: a btn edge reaches bs after 2 clk. A click sets pending on the tick edge, and evt_valid rises 1 clk later if idle.

Test Plan:
- Reset: hold rst_n=0 with btn=4'hF toggling -> evt_valid=0, pending=0, evt_drop=0. Release reset, btn=0 -> outputs stay 0.
- Clean click (DIV=4): btn[1]=1 for 3 ticks, then 0 for 2 ticks, evt_ready=1 -> pending=4'b0010, then evt_valid=1 with evt_id=1 for exactly one cycle, then pending=0.
- Glitch: btn[2]=1 for 1 tick, then 0 -> no pending, no evt_valid. High for 2 ticks then low for only 1 tick before going high again -> no event.
- Round-robin (evt_ready=1): clicks on buttons 0 and 2 complete on the same tick -> ids 0 then 2, separated by one idle cycle. Then clicks on buttons 1 and 3 on the same tick -> ids 3 then 1.
- Backpressure: evt_ready=0 after a btn[0] click -> evt_valid=1 and evt_id=0 stable for 20 cycles. A second btn[0] click meanwhile -> evt_drop pulses once. Raise evt_ready -> exactly one event delivered.
- Async reset while evt_valid=1 and pending=4'b1010 -> evt_valid and pending drop to 0 without a clock edge. After release, no stale events are offered.

Source files
------------

// File: rtl/button_event_if.sv
// -----------------------------------------------------------------------------
// button_event_if
// Click-event handshake between the button front end and its single consumer.
//
//   evt_valid : producer -> consumer, an event is being offered
//   evt_id    : producer -> consumer, index of the button whose click is offered
//   evt_ready : consumer -> producer, consumer takes the offered event this cycle
//
// An event transfers on a rising clock edge where evt_valid & evt_ready.
// The master modport is the producer (button_event_scheduler).
// The slave modport is the consumer.
// -----------------------------------------------------------------------------
interface button_event_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );
endinterface

// File: rtl/button_event_scheduler.sv
// -----------------------------------------------------------------------------
// button_event_scheduler
// Debounces N_BTN raw push-buttons and hands completed clicks, one at a time,
// to a single consumer.
//
// Each button goes through the following stages:
//   - a 2-flop synchroniser;
//   - a press/hold/release debounce FSM that advances only on a shared
//     prescaled sample tick;
//   - a pending-click flag.
// A round-robin arbiter offers the pending clicks over a valid/ready handshake.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   btn       : raw asynchronous button levels, 1 = pressed
//   evt       : event handshake (master side: evt_valid/evt_id out, evt_ready in)
//   pending   : per-button pending-click flags
//   evt_drop  : one-cycle pulse when a click is lost because its flag was
//               already set
// -----------------------------------------------------------------------------
module button_event_scheduler #(
    parameter int N_BTN = 4,
    parameter int ID_W  = 2,
    parameter int DIV   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn,
    button_event_if.master     evt,
    output logic [N_BTN-1:0]   pending,
    output logic               evt_drop
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] ST_WAIT     = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASED = 2'd3;

    // ------------------------------------------------------------------
    // Synchroniser and sample tick
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] bs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    assign bs = sync2_q;

    // With DIV=1 the counter is pinned at 0 == CNT_MAX, so tick is constant 1.
    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] click;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [1:0] st_q, st_d;
            logic       click_b;

            always_comb begin
                st_d    = st_q;
                click_b = 1'b0;
                if (tick) begin
                    case (st_q)
                        ST_WAIT:     st_d = bs[gi] ? ST_PRESSED : ST_WAIT;
                        // A single high sample is treated as a glitch.
                        ST_PRESSED:  st_d = bs[gi] ? ST_HELD : ST_WAIT;
                        ST_HELD:     st_d = bs[gi] ? ST_HELD : ST_RELEASED;
                        // A single low sample is a bounce.
                        // A second low sample completes the click.
                        ST_RELEASED: begin
                            if (bs[gi]) begin
                                st_d = ST_PRESSED;
                            end else begin
                                st_d    = ST_WAIT;
                                click_b = 1'b1;
                            end
                        end
                        default:     st_d = ST_WAIT;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_q <= ST_WAIT;
                end else begin
                    st_q <= st_d;
                end
            end

            assign click[gi] = click_b;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending flags and drop detection
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             drop_q, drop_d;
    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             hs;
    logic [N_BTN-1:0] clr;

    assign hs = valid_q & evt.evt_ready;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_clr
            assign clr[gi] = hs & (id_q == ID_W'(gi));
        end
    endgenerate

    // A click on the same edge as its own handshake re-arms the flag.
    // This case is not a drop: only clicks that land on a flag that stays
    // set are lost.
    always_comb begin
        pending_d = (pending_q & ~clr) | click;
        drop_d    = |(click & pending_q & ~clr);
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    int              idx;

    // The scan runs from the farthest candidate (ptr+N) down to the nearest
    // (ptr+1).
    // The last hit therefore wins, which is the first set bit after ptr.
    always_comb begin
        pick = '0;
        cand = '0;
        idx  = 0;
        for (int k = N_BTN; k >= 1; k--) begin
            idx  = (int'(ptr_q) + k) % N_BTN;
            cand = ID_W'(idx);
            if (pending_q[cand]) begin
                pick = cand;
            end
        end
    end

    // evt_valid drops on every handshake.
    // The next offer is computed from the already-cleared flags one cycle
    // later, so events are at least two cycles apart.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (valid_q) begin
            if (evt.evt_ready) begin
                valid_d = 1'b0;
                ptr_d   = id_q;
            end
        end else if (|pending_q) begin
            valid_d = 1'b1;
            id_d    = pick;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ptr_q     <= ID_W'(N_BTN - 1);
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign pending       = pending_q;
    assign evt_drop      = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_button_event_scheduler
// Directed stimulus with a scoreboard for button_event_scheduler (DIV=4).
//
// The stimulus pushes the expected event ids into exp_q.
// A negedge monitor pops one entry on each handshake and compares it with
// evt_id.
// Holding a button level for k*DIV cycles yields exactly k samples of that
// level, whatever the tick phase.
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;
    localparam int N_BTN = 4;
    localparam int ID_W  = 2;
    localparam int DIV   = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_BTN-1:0] btn   = '0;
    logic [N_BTN-1:0] pending;
    logic             evt_drop;

    button_event_if #(.ID_W(ID_W)) bus ();

    button_event_scheduler #(.N_BTN(N_BTN), .ID_W(ID_W), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .evt      (bus),
        .pending  (pending),
        .evt_drop (evt_drop)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int evt_count   = 0;
    int drop_count  = 0;
    int cycle       = 0;
    int hs_last     = 0;
    int hs_prev     = 0;
    bit saw_pending = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.evt_valid && bus.evt_ready) begin
            int e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got id %0d, expected no event", bus.evt_id);
            end else begin
                e = exp_q.pop_front();
                if (bus.evt_id !== ID_W'(e)) begin
                    miscompares++;
                    $display("FAIL event_id: got %0d, expected %0d", bus.evt_id, e);
                end else begin
                    $display("event id %0d delivered at cycle %0d", bus.evt_id, cycle);
                end
            end
            evt_count++;
            hs_prev = hs_last;
            hs_last = cycle;
        end
        if (rst_n && evt_drop) drop_count++;
        if (pending != '0) saw_pending = 1'b1;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            $display("check %s = 0x%0h", name, got);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pending(string name, logic [N_BTN-1:0] exp, int budget);
        int i = 0;
        while (pending == '0 && i < budget) begin
            cyc(1);
            i++;
        end
        check(name, 32'(pending), 32'(exp));
    endtask

    task automatic wait_valid(string name, int budget);
        int i = 0;
        while (!bus.evt_valid && i < budget) begin
            cyc(1);
            i++;
        end
        check(name, 32'(bus.evt_valid), 32'd1);
    endtask

    task automatic wait_events(string name, int target, int budget);
        int i = 0;
        while (evt_count < target && i < budget) begin
            cyc(1);
            i++;
        end
        check(name, 32'(evt_count), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int vc;
        int base;
        int d0;
        int stable;

        bus.evt_ready = 1'b0;

        // Reset with toggling buttons
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0) ? 4'hF : 4'h0;
            cyc(1);
        end
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(evt_drop), 32'd0);
        btn   = '0;
        rst_n = 1'b1;
        cyc(20);
        check("idle_valid", 32'(bus.evt_valid), 32'd0);
        check("idle_pending", 32'(pending), 32'd0);
        check("idle_events", 32'(evt_count), 32'd0);

        // Clean click on button 1
        bus.evt_ready = 1'b1;
        exp_q.push_back(1);
        btn[1] = 1'b1;
        cyc(3 * DIV);
        btn[1] = 1'b0;
        wait_pending("click_pending", 4'b0010, 30);
        vc = 0;
        repeat (10) begin
            cyc(1);
            if (bus.evt_valid) vc++;
        end
        check("click_valid_cycles", 32'(vc), 32'd1);
        check("click_pending_cleared", 32'(pending), 32'd0);
        check("click_events", 32'(evt_count), 32'd1);

        // Glitches on button 2
        saw_pending = 1'b0;
        btn[2] = 1'b1;
        cyc(1 * DIV);
        btn[2] = 1'b0;
        cyc(4 * DIV);
        btn[2] = 1'b1;
        cyc(2 * DIV);
        btn[2] = 1'b0;
        cyc(1 * DIV);
        btn[2] = 1'b1;
        cyc(3 * DIV);
        check("glitch_no_pending", 32'(saw_pending), 32'd0);
        check("glitch_no_event", 32'(evt_count), 32'd1);
        exp_q.push_back(2);
        btn[2] = 1'b0;
        wait_pending("glitch_final_pending", 4'b0100, 30);
        wait_events("glitch_final_event", 2, 20);

        // Round-robin
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(2);
        base = evt_count;
        btn  = 4'b0101;
        cyc(3 * DIV);
        btn = '0;
        wait_pending("rr1_pending", 4'b0101, 30);
        wait_events("rr1_events", base + 2, 20);
        check("rr1_gap", 32'(hs_last - hs_prev), 32'd2);
        exp_q.push_back(3);
        exp_q.push_back(1);
        base = evt_count;
        btn  = 4'b1010;
        cyc(3 * DIV);
        btn = '0;
        wait_pending("rr2_pending", 4'b1010, 30);
        wait_events("rr2_events", base + 2, 20);
        check("rr2_gap", 32'(hs_last - hs_prev), 32'd2);

        // Backpressure and drop
        do_reset();
        bus.evt_ready = 1'b0;
        btn[0] = 1'b1;
        cyc(3 * DIV);
        btn[0] = 1'b0;
        wait_valid("bp_valid", 40);
        d0     = drop_count;
        stable = 0;
        for (int i = 0; i < 28; i++) begin
            btn[0] = (i < 3 * DIV);
            cyc(1);
            if (bus.evt_valid === 1'b1 && bus.evt_id === 2'd0) stable++;
        end
        check("bp_stable_cycles", 32'(stable), 32'd28);
        check("bp_drop_pulses", 32'(drop_count - d0), 32'd1);
        check("bp_pending", 32'(pending), 32'b0001);
        exp_q.push_back(0);
        base = evt_count;
        bus.evt_ready = 1'b1;
        cyc(10);
        check("bp_one_event", 32'(evt_count - base), 32'd1);
        check("bp_pending_cleared", 32'(pending), 32'd0);

        // Asynchronous reset while an event is offered
        do_reset();
        bus.evt_ready = 1'b0;
        btn = 4'b1010;
        cyc(3 * DIV);
        btn = '0;
        wait_valid("ar_valid", 40);
        cyc(1);
        check("ar_pending_before", 32'(pending), 32'b1010);
        check("ar_id_before", 32'(bus.evt_id), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_async", 32'(bus.evt_valid), 32'd0);
        check("ar_pending_async", 32'(pending), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        base = evt_count;
        cyc(40);
        check("ar_no_stale_events", 32'(evt_count - base), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
